// File: rtl/vip_sync_pkg.sv
// vip_sync_pkg
// Shared constants and types for the multi-event sync generator.
//   - DEF_* : default widths used by vip_multi_sync_generation and its counter.
//   - raster_pos_t : (sub, h, v) raster position. It is sized to the widest
//     supported counters. Narrower instance counters are zero-extended into it.
package vip_sync_pkg;

    localparam int DEF_NUM_EVENTS = 2;
    localparam int DEF_H_WIDTH    = 14;
    localparam int DEF_V_WIDTH    = 13;
    localparam int DEF_SUB_WIDTH  = 2;
    localparam int DEF_PW_WIDTH   = 4;

    localparam int POS_SUB_W = 8;
    localparam int POS_H_W   = 16;
    localparam int POS_V_W   = 16;

    typedef struct packed {
        logic [POS_SUB_W-1:0] sub;
        logic [POS_H_W-1:0]   h;
        logic [POS_V_W-1:0]   v;
    } raster_pos_t;

endpackage

// File: rtl/vip_sync_hv_counter.sv
// vip_sync_hv_counter
// Subsample / sample / line counter. It is used for the output raster and for
// the rate divider.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   sclr      : synchronous clear to (0,0,0). It has priority over enable.
//   enable    : advance qualifier
//   hd_sdn    : 1 = every enable advances h (sub held at 0)
//               0 = sub counts and h advances when sub wraps
//   h_total   : samples per line (count, or last index when TOTALS_MINUS_ONE)
//   v_total   : lines per frame (same encoding)
//   sub, h, v : current position
//   wrap      : combinational. High when h wraps on this cycle's advance.
module vip_sync_hv_counter
    import vip_sync_pkg::*;
#(
    parameter int H_WIDTH          = DEF_H_WIDTH,
    parameter int V_WIDTH          = DEF_V_WIDTH,
    parameter int SUB_WIDTH        = DEF_SUB_WIDTH,
    parameter int TOTALS_MINUS_ONE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclr,
    input  logic                 enable,
    input  logic                 hd_sdn,
    input  logic [H_WIDTH-1:0]   h_total,
    input  logic [V_WIDTH-1:0]   v_total,
    output logic [SUB_WIDTH-1:0] sub,
    output logic [H_WIDTH-1:0]   h,
    output logic [V_WIDTH-1:0]   v,
    output logic                 wrap
);

    logic [H_WIDTH-1:0] h_last;
    logic [V_WIDTH-1:0] v_last;
    logic               h_adv;
    logic               h_at_last;
    logic               v_at_last;

    // A total of 0 in count mode underflows to all-ones. This is accepted
    // behaviour.
    assign h_last    = (TOTALS_MINUS_ONE != 0) ? h_total : h_total - 1'b1;
    assign v_last    = (TOTALS_MINUS_ONE != 0) ? v_total : v_total - 1'b1;
    assign h_adv     = hd_sdn | (&sub);
    assign h_at_last = (h == h_last);
    assign v_at_last = (v == v_last);
    assign wrap      = ~sclr & enable & h_adv & h_at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub <= '0;
            h   <= '0;
            v   <= '0;
        end else if (sclr) begin
            sub <= '0;
            h   <= '0;
            v   <= '0;
        end else if (enable) begin
            if (hd_sdn) begin
                sub <= '0;
            end else begin
                sub <= sub + 1'b1;
            end
            if (h_adv) begin
                if (h_at_last) begin
                    h <= '0;
                    if (v_at_last) begin
                        v <= '0;
                    end else begin
                        v <= v + 1'b1;
                    end
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vip_multi_sync_generation.sv
// vip_multi_sync_generation
// Multi-event sync generator for the clocked-video output path. It tracks the
// output raster with its own counter, which realigns on each field-0 vsync.
// It emits NUM_EVENTS programmable pulses (event 0 = start of frame), a
// divided-rate strobe gated by event 0, and a lock flag.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   clear_enable                 : drop tracking until the next field-0 vsync
//   enable_count                 : sample-clock qualifier
//   hd_sdn                       : 1 = one sample per qualified cycle
//   start_of_vsync, field_prediction : realign when vsync on field 0
//   interlaced                   : status only
//   total_sample_count(_valid)   : samples per line
//   total_line_count(_valid)     : lines per frame
//   stable                       : input timing stable
//   evt_sample/line/subsample    : per-event position, packed, event 0 in LSBs
//   evt_pulse_len                : per-event pulse width minus one
//   divider_value                : divider last index
//   output_enable                : output gate
//   evt, evt_locked, div         : outputs
module vip_multi_sync_generation
    import vip_sync_pkg::*;
#(
    parameter int NUM_EVENTS       = DEF_NUM_EVENTS,
    parameter int H_WIDTH          = DEF_H_WIDTH,
    parameter int V_WIDTH          = DEF_V_WIDTH,
    parameter int SUB_WIDTH        = DEF_SUB_WIDTH,
    parameter int PW_WIDTH         = DEF_PW_WIDTH,
    parameter int TOTALS_MINUS_ONE = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear_enable,
    input  logic                            enable_count,
    input  logic                            hd_sdn,
    input  logic                            start_of_vsync,
    input  logic                            field_prediction,
    input  logic                            interlaced,
    input  logic [H_WIDTH-1:0]              total_sample_count,
    input  logic                            total_sample_count_valid,
    input  logic [V_WIDTH-1:0]              total_line_count,
    input  logic                            total_line_count_valid,
    input  logic                            stable,
    input  logic [NUM_EVENTS*H_WIDTH-1:0]   evt_sample,
    input  logic [NUM_EVENTS*V_WIDTH-1:0]   evt_line,
    input  logic [NUM_EVENTS*SUB_WIDTH-1:0] evt_subsample,
    input  logic [NUM_EVENTS*PW_WIDTH-1:0]  evt_pulse_len,
    input  logic [H_WIDTH-1:0]              divider_value,
    input  logic                            output_enable,
    output logic [NUM_EVENTS-1:0]           evt,
    output logic                            evt_locked,
    output logic                            div
);

    logic sov_f0;
    logic en_next;
    logic enable;
    logic enable_r;
    logic count;

    assign sov_f0  = start_of_vsync & ~field_prediction;
    assign en_next = stable & total_sample_count_valid;
    // A field-0 vsync re-arms tracking. Otherwise, once dropped, it stays down.
    assign enable  = sov_f0 ? en_next : (en_next & enable_r & ~clear_enable);
    assign count   = enable & enable_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_r <= 1'b0;
        end else begin
            enable_r <= enable;
        end
    end

    // ---- raster position ----
    logic [SUB_WIDTH-1:0] ras_sub;
    logic [H_WIDTH-1:0]   ras_h;
    logic [V_WIDTH-1:0]   ras_v;
    logic                 ras_wrap;
    raster_pos_t          rpos;

    vip_sync_hv_counter #(
        .H_WIDTH          (H_WIDTH),
        .V_WIDTH          (V_WIDTH),
        .SUB_WIDTH        (SUB_WIDTH),
        .TOTALS_MINUS_ONE (TOTALS_MINUS_ONE)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .sclr    (sov_f0),
        .enable  (count),
        .hd_sdn  (hd_sdn),
        .h_total (total_sample_count),
        .v_total (total_line_count),
        .sub     (ras_sub),
        .h       (ras_h),
        .v       (ras_v),
        .wrap    (ras_wrap)
    );

    always_comb begin
        rpos     = '0;
        rpos.sub = POS_SUB_W'(ras_sub);
        rpos.h   = POS_H_W'(ras_h);
        rpos.v   = POS_V_W'(ras_v);
    end

    // ---- shadow configuration ----
    // The shadows reload while tracking is down or on a field-0 vsync. This
    // means a mid-frame change lands cleanly at the next frame start.
    logic [NUM_EVENTS*H_WIDTH-1:0]   sh_sample;
    logic [NUM_EVENTS*V_WIDTH-1:0]   sh_line;
    logic [NUM_EVENTS*SUB_WIDTH-1:0] sh_sub;
    logic [NUM_EVENTS*PW_WIDTH-1:0]  sh_len;
    logic [H_WIDTH-1:0]              sh_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_sample <= '0;
            sh_line   <= '0;
            sh_sub    <= '0;
            sh_len    <= '0;
            sh_div    <= '0;
        end else if (~enable | sov_f0) begin
            sh_sample <= evt_sample;
            sh_line   <= evt_line;
            sh_sub    <= evt_subsample;
            sh_len    <= evt_pulse_len;
            sh_div    <= divider_value;
        end
    end

    // ---- event matchers and pulse stretchers ----
    logic [NUM_EVENTS-1:0] match;

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_evt
        logic [H_WIDTH-1:0]   e_h;
        logic [V_WIDTH-1:0]   e_v;
        logic [SUB_WIDTH-1:0] e_sub;
        logic [PW_WIDTH-1:0]  e_len;
        logic [PW_WIDTH-1:0]  pc;
        logic                 evt_q;

        assign e_h   = sh_sample[i*H_WIDTH +: H_WIDTH];
        assign e_v   = sh_line[i*V_WIDTH +: V_WIDTH];
        assign e_sub = sh_sub[i*SUB_WIDTH +: SUB_WIDTH];
        assign e_len = sh_len[i*PW_WIDTH +: PW_WIDTH];

        assign match[i] = count
                        & (hd_sdn | (POS_SUB_W'(e_sub) == rpos.sub))
                        & (POS_H_W'(e_h) == rpos.h)
                        & (POS_V_W'(e_v) == rpos.v);

        // A running pulse ignores new matches, so it is never retriggered or
        // stretched.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                evt_q <= 1'b0;
                pc    <= '0;
            end else if (!output_enable) begin
                evt_q <= 1'b0;
                pc    <= '0;
            end else if (pc == '0) begin
                if (match[i]) begin
                    evt_q <= 1'b1;
                    pc    <= e_len;
                end else begin
                    evt_q <= 1'b0;
                end
            end else begin
                pc <= pc - 1'b1;
            end
        end

        assign evt[i] = evt_q;
    end

    // ---- divider, armed by the first start-of-frame event ----
    logic       match0_r;
    logic       first_evt;
    logic       div_wrap;
    logic       div_sub;
    logic [H_WIDTH-1:0] div_h;
    logic       div_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match0_r  <= 1'b0;
            first_evt <= 1'b0;
        end else begin
            match0_r <= match[0];
            if (!output_enable) begin
                first_evt <= 1'b0;
            end else begin
                first_evt <= enable & (match[0] | first_evt);
            end
        end
    end

    // The divider reuses the counter in hd mode, with the last index taken
    // directly from divider_value and a single-line frame. Each start of
    // frame realigns it one cycle later.
    vip_sync_hv_counter #(
        .H_WIDTH          (H_WIDTH),
        .V_WIDTH          (1),
        .SUB_WIDTH        (1),
        .TOTALS_MINUS_ONE (1)
    ) u_divider (
        .clk     (clk),
        .rst     (rst),
        .sclr    (match0_r | ~output_enable),
        .enable  (count & first_evt),
        .hd_sdn  (1'b1),
        .h_total (sh_div),
        .v_total (1'b0),
        .sub     (div_sub),
        .h       (div_h),
        .v       (div_v),
        .wrap    (div_wrap)
    );

    // ---- registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= 1'b0;
            evt_locked <= 1'b0;
        end else begin
            div        <= output_enable & div_wrap;
            evt_locked <= output_enable & enable & total_line_count_valid;
        end
    end

    logic unused_sigs;
    assign unused_sigs = ^{interlaced, ras_wrap, div_sub, div_h, div_v};

endmodule

// File: tb/tb_vip_multi_sync_generation.sv
// tb_vip_multi_sync_generation
// Directed bench for vip_multi_sync_generation with default parameters.
// Outputs are sampled and inputs are driven 1 time unit after each rising edge.
// k counts the edges since the last field-0 vsync cycle.
module tb_vip_multi_sync_generation;

    localparam int NE = 2;
    localparam int HW = 14;
    localparam int VW = 13;
    localparam int SW = 2;
    localparam int PW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear_enable = 1'b0;
    logic              enable_count = 1'b0;
    logic              hd_sdn = 1'b1;
    logic              start_of_vsync = 1'b0;
    logic              field_prediction = 1'b0;
    logic              interlaced = 1'b0;
    logic [HW-1:0]     total_sample_count = '0;
    logic              total_sample_count_valid = 1'b0;
    logic [VW-1:0]     total_line_count = '0;
    logic              total_line_count_valid = 1'b0;
    logic              stable = 1'b0;
    logic [NE*HW-1:0]  evt_sample = '0;
    logic [NE*VW-1:0]  evt_line = '0;
    logic [NE*SW-1:0]  evt_subsample = '0;
    logic [NE*PW-1:0]  evt_pulse_len = '0;
    logic [HW-1:0]     divider_value = '0;
    logic              output_enable = 1'b0;
    logic [NE-1:0]     evt;
    logic              evt_locked;
    logic              div;

    int n_vec = 0;
    int n_err = 0;
    int k = 0;

    vip_multi_sync_generation dut (
        .clk                      (clk),
        .rst                      (rst),
        .clear_enable             (clear_enable),
        .enable_count             (enable_count),
        .hd_sdn                   (hd_sdn),
        .start_of_vsync           (start_of_vsync),
        .field_prediction         (field_prediction),
        .interlaced               (interlaced),
        .total_sample_count       (total_sample_count),
        .total_sample_count_valid (total_sample_count_valid),
        .total_line_count         (total_line_count),
        .total_line_count_valid   (total_line_count_valid),
        .stable                   (stable),
        .evt_sample               (evt_sample),
        .evt_line                 (evt_line),
        .evt_subsample            (evt_subsample),
        .evt_pulse_len            (evt_pulse_len),
        .divider_value            (divider_value),
        .output_enable            (output_enable),
        .evt                      (evt),
        .evt_locked               (evt_locked),
        .div                      (div)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    typedef struct {
        int           edge_n;
        logic [NE-1:0] evt;
        logic         div;
        logic         lock;
        int           new_s0;   // >=0: reprogram evt_sample[0] after this check
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int e, logic [NE-1:0] ev, logic d, logic l, int s0);
        vec_t r;
        r.edge_n = e;
        r.evt    = ev;
        r.div    = d;
        r.lock   = l;
        r.new_s0 = s0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check_all(input string name, input logic [NE-1:0] e_evt,
                             input logic e_div, input logic e_lock);
        n_vec++;
        if (evt !== e_evt || div !== e_div || evt_locked !== e_lock) begin
            n_err++;
            $display("FAIL %s k=%0d: got evt=%b div=%b locked=%b, want evt=%b div=%b locked=%b",
                     name, k, evt, div, evt_locked, e_evt, e_div, e_lock);
        end
    endtask

    task automatic check_evt(input string name, input logic [NE-1:0] e_evt);
        n_vec++;
        if (evt !== e_evt) begin
            n_err++;
            $display("FAIL %s k=%0d: got evt=%b, want evt=%b", name, k, evt, e_evt);
        end
    endtask

    task automatic sov_cycle();
        start_of_vsync   = 1'b1;
        field_prediction = 1'b0;
        enable_count     = 1'b0;
        tick();
        start_of_vsync   = 1'b0;
        enable_count     = 1'b1;
        k = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_all("reset_state", '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Scenario A: hd, 10 samples x 5 lines, evt0 @(3,2) len0, evt1 @(0,0) len3, divider 3.
        // Frame = 50 counts. Position during cycle k is linear index k-1.
        tbl.push_back(mk( 0, 2'b00, 1'b0, 1'b1, -1));
        tbl.push_back(mk( 1, 2'b10, 1'b0, 1'b1, -1));
        tbl.push_back(mk( 4, 2'b10, 1'b0, 1'b1, -1));
        tbl.push_back(mk( 5, 2'b00, 1'b0, 1'b1, -1));
        tbl.push_back(mk(23, 2'b00, 1'b0, 1'b1, -1));
        tbl.push_back(mk(24, 2'b01, 1'b0, 1'b1, -1));
        tbl.push_back(mk(25, 2'b00, 1'b0, 1'b1, -1));
        tbl.push_back(mk(28, 2'b00, 1'b0, 1'b1, -1));
        tbl.push_back(mk(29, 2'b00, 1'b1, 1'b1, -1));
        tbl.push_back(mk(30, 2'b00, 1'b0, 1'b1, -1));
        tbl.push_back(mk(33, 2'b00, 1'b1, 1'b1, -1));
        tbl.push_back(mk(51, 2'b10, 1'b0, 1'b1, -1));
        tbl.push_back(mk(54, 2'b10, 1'b0, 1'b1, -1));
        tbl.push_back(mk(55, 2'b00, 1'b0, 1'b1, -1));
        tbl.push_back(mk(60, 2'b00, 1'b0, 1'b1,  7));
        tbl.push_back(mk(73, 2'b00, 1'b1, 1'b1, -1));
        tbl.push_back(mk(74, 2'b01, 1'b0, 1'b1, -1));
        tbl.push_back(mk(77, 2'b00, 1'b0, 1'b1, -1));
        tbl.push_back(mk(79, 2'b00, 1'b1, 1'b1, -1));

        hd_sdn                   = 1'b1;
        stable                   = 1'b1;
        total_sample_count       = 14'd10;
        total_sample_count_valid = 1'b1;
        total_line_count         = 13'd5;
        total_line_count_valid   = 1'b1;
        evt_sample               = {14'd0, 14'd3};
        evt_line                 = {13'd0, 13'd2};
        evt_subsample            = {2'd0, 2'd0};
        evt_pulse_len            = {4'd3, 4'd0};
        divider_value            = 14'd3;
        output_enable            = 1'b1;
        do_reset();

        // Tracking stays down until the first field-0 vsync.
        tick();
        tick();
        check_all("idle_no_sov", 2'b00, 1'b0, 1'b0);

        sov_cycle();
        foreach (tbl[j]) begin
            while (k < tbl[j].edge_n) tick();
            check_all($sformatf("A_k%0d", tbl[j].edge_n), tbl[j].evt, tbl[j].div, tbl[j].lock);
            if (tbl[j].new_s0 >= 0) evt_sample[HW-1:0] = HW'(tbl[j].new_s0);
        end

        // The reprogrammed sample position takes effect only after the next vsync.
        while (k < 80) tick();
        sov_cycle();
        while (k < 24) tick();
        check_evt("A_old_pos_gone", 2'b00);
        while (k < 28) tick();
        check_evt("A_new_pos", 2'b01);

        // Scenario B: 3x1 raster, evt1 @(0,0) len3 matches every 3 counts.
        // The match inside the 4-cycle window is ignored.
        total_sample_count = 14'd3;
        total_line_count   = 13'd1;
        evt_sample         = {14'd0, 14'd3};
        do_reset();
        sov_cycle();
        check_all("B_k0", 2'b00, 1'b0, 1'b1);
        for (int j = 1; j <= 13; j++) begin
            tick();
            check_evt($sformatf("B_noretrig_k%0d", j), (((j - 1) % 6) < 4) ? 2'b10 : 2'b00);
        end
        output_enable = 1'b0;
        tick();
        check_all("B_oe_low", 2'b00, 1'b0, 1'b0);
        output_enable = 1'b1;
        tick();
        check_all("B_oe_back", 2'b00, 1'b0, 1'b1);
        tick();
        check_evt("B_after_oe_k16", 2'b10);
        while (k < 19) tick();
        check_evt("B_after_oe_k19", 2'b10);
        tick();
        check_evt("B_after_oe_k20", 2'b00);

        clear_enable = 1'b1;
        tick();
        check_all("B_clear", 2'b00, 1'b0, 1'b0);
        clear_enable = 1'b0;
        repeat (4) tick();
        check_all("B_cleared_hold", 2'b00, 1'b0, 1'b0);
        sov_cycle();
        check_all("B_resume_k0", 2'b00, 1'b0, 1'b1);
        tick();
        check_all("B_resume_k1", 2'b10, 1'b0, 1'b1);
        tick();
        check_evt("B_resume_k2", 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check_all("B_rst_async", 2'b00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Scenario C: sd mode, 4 subsamples x 4 samples x 2 lines, evt0 @ sub2,h1,v0.
        // The match is at linear count 6 (frame of 32). evt1 sits on an unreachable line.
        hd_sdn             = 1'b0;
        total_sample_count = 14'd4;
        total_line_count   = 13'd2;
        evt_sample         = {14'd0, 14'd1};
        evt_line           = {13'd7, 13'd0};
        evt_subsample      = {2'd0, 2'd2};
        evt_pulse_len      = {4'd0, 4'd0};
        do_reset();
        sov_cycle();
        while (k < 6) tick();
        check_all("C_sub1", 2'b00, 1'b0, 1'b1);
        tick();
        check_all("C_sub2_hit", 2'b01, 1'b0, 1'b1);
        tick();
        check_all("C_sub3", 2'b00, 1'b0, 1'b1);
        while (k < 11) tick();
        check_all("C_div_k11", 2'b00, 1'b0, 1'b1);
        tick();
        check_all("C_div_k12", 2'b00, 1'b1, 1'b1);
        while (k < 38) tick();
        check_evt("C_f2_k38", 2'b00);
        tick();
        check_evt("C_f2_k39", 2'b01);
        tick();
        check_evt("C_f2_k40", 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
